// File: rtl/nco_sd_dac.sv
`default_nettype none
// ============================================================================
//  Module   : nco_sd_dac
//  Purpose  : Tone output stage downstream of the NCO. Captures signed sine
//             samples, applies a click-free ramped amplitude envelope with
//             programmable gain, converts to offset binary and drives a
//             first-order delta-sigma 1-bit stream (buzzer pin).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   system clock
//    reset_n   in   asynchronous active-low reset
//    clken     in   sample-rate enable (shared with the NCO)
//    fsin_i    in   [mpr]  signed sample from the NCO
//    in_valid  in   NCO sample valid
//    enable    in   tone-on request
//    gain      in   [gw]   unsigned target amplitude
//    dsm_o     out  registered delta-sigma bit stream
//    active_o  out  high while the envelope state is not IDLE
// ============================================================================
module nco_sd_dac #(
  parameter int mpr   = 16,
  parameter int gw    = 8,
  parameter int rampw = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic [mpr-1:0] fsin_i,
  input  logic           in_valid,
  input  logic           enable,
  input  logic [gw-1:0]  gain,
  output logic           dsm_o,
  output logic           active_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RUN       = 2'd1;
  localparam logic [1:0] S_RAMP_UP   = 2'd2;
  localparam logic [1:0] S_RAMP_DOWN = 2'd3;

  localparam logic [gw-1:0]    c_env_one = gw'(1);
  localparam logic [rampw-1:0] c_pc_one  = rampw'(1);
  localparam logic [mpr-1:0]   c_mid     = {1'b1, {(mpr-1){1'b0}}};

  logic [mpr-1:0]   r_s1;
  logic [rampw-1:0] r_pc;
  logic [gw-1:0]    r_env;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [mpr-1:0]   r_y;
  logic [mpr-1:0]   r_u;
  logic [mpr-1:0]   r_acc;
  logic             r_dsm;
  logic             w_active;

  logic [gw-1:0]           w_tgt;
  logic                    w_tick;
  logic signed [mpr+gw:0]  w_s1_ext;
  logic signed [mpr+gw:0]  w_env_ext;
  logic signed [mpr+gw:0]  w_prod;
  logic [mpr:0]            w_sum;
  logic                    w_unused_prod;

  assign w_tgt  = enable ? gain : '0;
  assign w_tick = clken & (&r_pc);

  // Envelope is zero-extended so it always acts as a non-negative multiplier;
  // with env <= 2^gw-1 the shifted result never exceeds the input magnitude.
  assign w_s1_ext  = {{(gw+1){r_s1[mpr-1]}}, r_s1};
  assign w_env_ext = {{(mpr+1){1'b0}}, r_env};
  assign w_prod    = w_s1_ext * w_env_ext;
  assign w_unused_prod = ^{w_prod[mpr+gw], w_prod[gw-1:0]};

  // The carry out of the accumulator is the modulator bit.
  assign w_sum = {1'b0, r_acc} + {1'b0, r_u};

  // Sample capture, prescaler, envelope and datapath pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= '0;
      r_pc  <= '0;
      r_env <= '0;
      r_y   <= '0;
      r_u   <= c_mid;
    end else if (clken) begin
      r_s1 <= in_valid ? fsin_i : '0;
      r_pc <= r_pc + c_pc_one;
      // Steps exactly one code toward target per tick, so it can never
      // overshoot or wrap.
      if (w_tick) begin
        if (r_env < w_tgt)      r_env <= r_env + c_env_one;
        else if (r_env > w_tgt) r_env <= r_env - c_env_one;
      end
      r_y <= w_prod[mpr+gw-1:gw];
      r_u <= r_y ^ c_mid;
    end
  end

  // Delta-sigma modulator runs at full clock rate on the held u.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_dsm <= 1'b0;
    end else begin
      r_acc <= w_sum[mpr-1:0];
      r_dsm <= w_sum[mpr];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state is a pure decode of the current env/target relation.
  always_comb begin
    w_state_nxt = r_state;
    if (clken) begin
      if (r_env < w_tgt)      w_state_nxt = S_RAMP_UP;
      else if (r_env > w_tgt) w_state_nxt = S_RAMP_DOWN;
      else if (w_tgt == '0)   w_state_nxt = S_IDLE;
      else                    w_state_nxt = S_RUN;
    end
  end

  // Output decode.
  always_comb begin
    w_active = (r_state != S_IDLE);
  end

  assign active_o = w_active;
  assign dsm_o    = r_dsm;

endmodule
`default_nettype wire

// File: doc/nco_sd_dac.md
# nco_sd_dac

Tone-output stage placed directly downstream of the NCO. It captures the NCO's signed sine samples (`fsin_o` / `out_valid`) and applies a click-free amplitude envelope with programmable gain. It converts the scaled sample to offset binary and drives a first-order delta-sigma 1-bit stream, the audio/buzzer pin of the traffic controller.

## Interface
Parameters:
- `mpr`, 16, sample width (matches NCO output width).
- `gw`, 8, gain/envelope width (unsigned).
- `rampw`, 10, envelope step prescaler width; one step every 2^rampw clken cycles.

Ports:
- `clk`, input, 1, system clock.
- `reset_n`, input, 1, asynchronous active-low reset.
- `clken`, input, 1, sample-rate enable, same net that drives the NCO.
- `fsin_i`, input, mpr, signed two's-complement sample from the NCO.
- `in_valid`, input, 1, NCO `out_valid`.
- `enable`, input, 1, tone on request.
- `gain`, input, gw, target amplitude, unsigned; 2^gw-1 = maximum.
- `dsm_o`, output, 1, registered delta-sigma bit stream.
- `active_o`, output, 1, high while state ≠ IDLE.

## Operation
- Capture register `s1` (mpr), updated on clken: `s1 <= in_valid ? fsin_i : 0`.
- Envelope target `tgt = enable ? gain : 0`.
- Prescaler `pc` (rampw bits) increments on every clken and wraps. `tick = clken & (pc == all ones)`.
- Envelope `env` (gw bits) updates on tick only:
  - steps +1 when env < tgt;
  - steps −1 when env > tgt;
  - holds when equal.
  - It never overshoots and never wraps.
- State register, updated on every clken from the current env/tgt:
  - IDLE when env==tgt and tgt==0;
  - RUN when env==tgt and tgt≠0;
  - RAMP_UP when env<tgt;
  - RAMP_DOWN when env>tgt.
- Resulting transitions:
  - enable rising: IDLE→RAMP_UP→RUN.
  - enable falling: RUN or RAMP_UP→RAMP_DOWN→IDLE, ramping down from the current env.
  - gain change in RUN: moves to RAMP_UP or RAMP_DOWN, then back to RUN.
  - gain=0 with enable=1: stays in IDLE.
- Scaling stage, registered on clken:
  - `prod = s1 * {1'b0,env}`, signed, mpr+gw+1 bits.
  - `y = prod[mpr+gw-1:gw]`, i.e. arithmetic shift right by gw.
  - |y| ≤ |s1|, so no saturation is required.
- Offset conversion, registered on clken: `u <= y ^ (1<<(mpr-1))`.
- Delta-sigma modulator runs on every clk, independent of clken:
  - `acc` (mpr+1 bits): `acc <= {1'b0,acc[mpr-1:0]} + u`.
  - `dsm_o <= carry` of that sum, i.e. the new acc[mpr].
  - Ones density = u / 2^mpr.
- With clken low, s1, pc, env, state, prod and u hold; the DSM continues on the held u.
- Reset (asynchronous, any time):
  - s1, pc, env, prod, acc and dsm_o all clear to 0;
  - u = 2^(mpr-1) (midscale);
  - state = IDLE, active_o = 0.

## Timing
- Sample path: fsin_i sampled at clken edge k; y valid after edge k+1; u after edge k+2.
  - DSM carry reflecting the new u appears on dsm_o one clk after u updates.
- active_o is the registered state decode.
  - It rises on the first clken edge after enable=1 with gain≠0.
  - It falls on the clken edge following env reaching 0.
- Full ramp 0→G takes G × 2^rampw clken cycles, ±1 step for prescaler phase. The prescaler is free-running and is not reset on enable.
- After reset with idle inputs, u=0x8000 and acc starts at 0, so dsm_o = 0,1,0,1,… with the first 1 on the second clk edge after reset release.
- Simultaneous tick and tgt change: env steps toward the new tgt in that same update.

## Test plan
- Reset release, enable=0, clken=1: active_o=0 and u=0x8000; dsm_o alternates 0,1,0,1 starting 0; assert reset_n mid-stream → dsm_o=0 immediately.
- rampw=2, enable=1, gain=255, clken=1: env reaches 255 within 255×4 (±4) clken cycles; active_o=1 from the first clken; state RUN afterwards.
- RUN, env=255, fsin_i=0x4000 constant: y=0x3FC0, u=0xBFC0; exactly 49088 ones on dsm_o over 65536 clks.
- RUN, env=255, fsin_i=0x8000: y=0x8080, u=0x0080; 128 ones per 65536 clks.
- Drop enable when env=100 in RAMP_UP: env decrements to 0 over 100 ticks, then IDLE; active_o falls; u returns to 0x8000.
- in_valid=0 while in RUN: u=0x8000 two clken cycles later; clken held low 50 cycles → u, env and state frozen while dsm_o keeps toggling.
